// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals shared by mem_port_arbiter.
// The "master" modport is the arbiter's view, since it drives the memory bus.
// The "slave" modport is the view of the clients and the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and load/store data. Data wins conflicts, except that after MAX_D_BURST data
// grants with fetch waiting, fetch wins the next conflict.
// Optional macro ARB_PERF_CNT_EN enables the perf_i_wait/perf_d_wait stall
// counters. Without it, those ports are tied to 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access in flight, arbitrating between i_req and d_req
// I_BUSY | fetch access presented to memory, waiting for mem_ready
// D_BUSY | data access presented to memory, waiting for mem_ready
// RESP   | one-cycle ack and rdata toward the client that owned the access
module mem_port_arbiter #(
    parameter int MAX_D_BURST = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus,
    output logic [31:0]        perf_i_wait,
    output logic [31:0]        perf_d_wait
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);

    state_t            state;
    logic [3:0]        burst_cnt;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    // The ack pair doubles as the owner record of the completed access.
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              fetch_wins;

    // Fetch wins only when it has waited out a full data burst.
    assign fetch_wins = bus.i_req && (!bus.d_req || burst_cnt == BURST_MAX);

    // Arbitration FSM with registered memory-side and client-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_wins) begin
                        state       <= I_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.i_addr;
                        mem_wdata_q <= '0;
                        burst_cnt   <= '0;
                    end else if (bus.d_req) begin
                        state       <= D_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        if (bus.i_req && burst_cnt != BURST_MAX)
                            burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (bus.mem_ready) begin
                        state     <= RESP;
                        mem_req_q <= 1'b0;
                        if (state == D_BUSY) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= bus.mem_rdata;
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    i_ack_q   <= 1'b0;
                    d_ack_q   <= 1'b0;
                    i_rdata_q <= '0;
                    d_rdata_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_q;
    logic [31:0] perf_d_q;

    // Stall-cycle counters: request pending without its ack, wrapping freely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
        end else begin
            if (bus.i_req && !i_ack_q)
                perf_i_q <= perf_i_q + 32'd1;
            if (bus.d_req && !d_ack_q)
                perf_d_q <= perf_d_q + 32'd1;
        end
    end

    assign perf_i_wait = perf_i_q;
    assign perf_d_wait = perf_d_q;
`else
    assign perf_i_wait = '0;
    assign perf_d_wait = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: lone fetch, conflict, burst fairness,
// wait states, mid-access reset and the optional stall counters.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] perf_i_wait;
    logic [31:0] perf_d_wait;
    int          total = 0;
    int          bad = 0;
    logic [9:0]  exp_d_order = 10'b0111101111;
    logic        got;
    logic [31:0] exp_perf_i;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.MAX_D_BURST(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master),
        .perf_i_wait (perf_i_wait),
        .perf_d_wait (perf_d_wait)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef ARB_PERF_CNT_EN
        exp_perf_i = 32'd5;
`else
        exp_perf_i = 32'd0;
`endif
        reset = 1'b1;
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b1;
        #12;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_i_ack", bus.i_ack, 0);
        chk("rst_d_ack", bus.d_ack, 0);
        chk("rst_perf_i", perf_i_wait, 0);
        reset = 1'b0;
        step();

        // Lone fetch
        bus.i_req = 1'b1;
        bus.i_addr = 32'h100;
        bus.mem_rdata = 32'h13;
        step();
        chk("f_mem_req", bus.mem_req, 1);
        chk("f_mem_addr", bus.mem_addr, 32'h100);
        chk("f_mem_we", bus.mem_we, 0);
        chk("f_early_ack", bus.i_ack, 0);
        step();
        chk("f_i_ack", bus.i_ack, 1);
        chk("f_i_rdata", bus.i_rdata, 32'h13);
        chk("f_d_ack", bus.d_ack, 0);
        chk("f_resp_mem_req", bus.mem_req, 0);
        bus.i_req = 1'b0;
        step();
        chk("f_ack_drop", bus.i_ack, 0);
        chk("f_rdata_drop", bus.i_rdata, 0);

        // Simultaneous requests: data first, fetch three cycles after d_ack
        bus.i_req = 1'b1;
        bus.i_addr = 32'h104;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h2000;
        bus.d_wdata = 32'hDEADBEEF;
        bus.mem_rdata = 32'h55;
        step();
        chk("c_mem_we", bus.mem_we, 1);
        chk("c_mem_addr", bus.mem_addr, 32'h2000);
        chk("c_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        step();
        chk("c_d_ack", bus.d_ack, 1);
        chk("c_i_ack_not_yet", bus.i_ack, 0);
        bus.d_req = 1'b0;
        step();
        chk("c_i_ack_plus1", bus.i_ack, 0);
        step();
        chk("c_fetch_addr", bus.mem_addr, 32'h104);
        chk("c_fetch_we", bus.mem_we, 0);
        step();
        chk("c_i_ack_plus3", bus.i_ack, 1);
        chk("c_i_rdata", bus.i_rdata, 32'h55);
        bus.i_req = 1'b0;
        step();

        // Burst fairness: both held, grant order D,D,D,D,I,D,D,D,D,I
        bus.i_req = 1'b1;
        bus.i_addr = 32'h400;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h4000;
        for (int k = 0; k < 10; k++) begin
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                step();
                if (bus.i_ack || bus.d_ack) got = 1'b1;
            end
            chk($sformatf("b_ack_seen%0d", k), got, 1);
            chk($sformatf("b_owner%0d", k), bus.d_ack, exp_d_order[k]);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();

        // Wait states on a data load
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h3000;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hAAAA0000;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("w_mem_req%0d", c), bus.mem_req, 1);
            chk($sformatf("w_mem_addr%0d", c), bus.mem_addr, 32'h3000);
            chk($sformatf("w_no_ack%0d", c), bus.d_ack, 0);
            bus.mem_rdata = 32'hAAAA0001 + c;
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h12345678;
        step();
        chk("w_d_ack", bus.d_ack, 1);
        chk("w_d_rdata", bus.d_rdata, 32'h12345678);
        bus.d_req = 1'b0;
        step();

        // Reset in the middle of a fetch
        bus.i_req = 1'b1;
        bus.i_addr = 32'h200;
        bus.mem_ready = 1'b0;
        step();
        chk("r_busy_mem_req", bus.mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("r_mem_req_drop", bus.mem_req, 0);
        chk("r_no_ack", bus.i_ack, 0);
        #2 reset = 1'b0;
        bus.i_req = 1'b0;
        step();
        chk("r_idle_mem_req", bus.mem_req, 0);
        chk("r_idle_ack", bus.i_ack, 0);
        bus.i_req = 1'b1;
        bus.i_addr = 32'h204;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h77;
        step();
        chk("r_new_mem_req", bus.mem_req, 1);
        chk("r_new_addr", bus.mem_addr, 32'h204);
        step();
        chk("r_new_ack", bus.i_ack, 1);
        chk("r_new_rdata", bus.i_rdata, 32'h77);
        bus.i_req = 1'b0;
        step();

        // Stall counters: fetch with three wait states
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        bus.i_req = 1'b1;
        bus.i_addr = 32'h300;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h99;
        for (int c = 0; c < 4; c++) step();
        chk("p_no_ack_yet", bus.i_ack, 0);
        bus.mem_ready = 1'b1;
        step();
        chk("p_i_ack", bus.i_ack, 1);
        chk("p_i_rdata", bus.i_rdata, 32'h99);
        chk("p_perf_i", perf_i_wait, exp_perf_i);
        chk("p_perf_d", perf_d_wait, 0);
        bus.i_req = 1'b0;
        step();
        chk("p_perf_i_hold", perf_i_wait, exp_perf_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
